// File: rtl/mem_map_pkg.sv
// Shared region encoding and default map constants for the memory-mapped
// RAM / screen / keyboard block.
package mem_map_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_RAM_DEPTH    = 16384;
    localparam int DEF_SCREEN_BASE  = 16384;
    localparam int DEF_SCREEN_DEPTH = 8192;
    localparam int DEF_KBD_ADDR     = 24576;

    typedef enum logic [1:0] {
        REG_RAM     = 2'd0,
        REG_SCREEN  = 2'd1,
        REG_KBD     = 2'd2,
        REG_ILLEGAL = 2'd3
    } region_e;

endpackage

// File: rtl/dp_ram.sv
// Read-first memory with one read/write port (A) and one read-only port (B);
// both read ports are registered and reset to zero, the array is not cleared.
module dp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_a,
    input  logic [WIDTH-1:0] wdata_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    addr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_a_r;
    logic [WIDTH-1:0] rdata_b_r;

    // Array write; a write coinciding with reset assertion is discarded.
    always_ff @(posedge clk) begin
        if (we_a && rst_n) begin
            mem_r[addr_a] <= wdata_a;
        end
    end

    // Registered reads sample the array before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a_r <= {WIDTH{1'b0}};
            rdata_b_r <= {WIDTH{1'b0}};
        end else begin
            rdata_a_r <= mem_r[addr_a];
            rdata_b_r <= mem_r[addr_b];
        end
    end

    assign rdata_a = rdata_a_r;
    assign rdata_b = rdata_b_r;

endmodule

// File: rtl/mapped_memory.sv
// CPU data memory map: RAM, screen buffer and keyboard register on one bus,
// with a registered read, error pulse and an independent display read port.
module mapped_memory
    import mem_map_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = 15,
    parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
    parameter int SCREEN_BASE  = DEF_SCREEN_BASE,
    parameter int SCREEN_DEPTH = DEF_SCREEN_DEPTH,
    parameter int SCREEN_AW    = $clog2(SCREEN_DEPTH),
    parameter int KBD_ADDR     = DEF_KBD_ADDR,
    parameter bit KBD_LATCH    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  load,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  addr_error,
    input  logic [DATA_WIDTH-1:0] kbd_code,
    input  logic                  kbd_strobe,
    output logic                  kbd_pending,
    input  logic [SCREEN_AW-1:0]  scr_rd_addr,
    output logic [DATA_WIDTH-1:0] scr_rd_data
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);

    // One extra bit so SCREEN_BASE+SCREEN_DEPTH cannot wrap.
    localparam logic [ADDR_WIDTH:0] RAM_HI = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] SCR_LO = (ADDR_WIDTH+1)'(SCREEN_BASE);
    localparam logic [ADDR_WIDTH:0] SCR_HI = (ADDR_WIDTH+1)'(SCREEN_BASE + SCREEN_DEPTH);
    localparam logic [ADDR_WIDTH:0] KBD_A  = (ADDR_WIDTH+1)'(KBD_ADDR);

    logic [ADDR_WIDTH:0]   addr_ext_s;
    region_e               region_s;
    region_e               region_q_r;
    logic                  ram_we_s;
    logic                  scr_we_s;
    logic                  kbd_rd_s;
    logic [RAM_AW-1:0]     ram_addr_s;
    logic [SCREEN_AW-1:0]  scr_addr_s;
    logic [DATA_WIDTH-1:0] ram_q_s;
    logic [DATA_WIDTH-1:0] scr_q_s;
    logic [DATA_WIDTH-1:0] ram_b_unused_s;
    logic [DATA_WIDTH-1:0] kbd_r;
    logic [DATA_WIDTH-1:0] kbd_q_r;
    logic                  kbd_pending_r;
    logic                  addr_error_r;
    logic [DATA_WIDTH-1:0] out_s;

    assign addr_ext_s = {1'b0, address};
    assign ram_addr_s = address[RAM_AW-1:0];
    assign scr_addr_s = SCREEN_AW'(address - ADDR_WIDTH'(SCREEN_BASE));

    // Address decode into one of the four regions.
    always_comb begin
        region_s = REG_ILLEGAL;
        if (addr_ext_s < RAM_HI) begin
            region_s = REG_RAM;
        end else if ((addr_ext_s >= SCR_LO) && (addr_ext_s < SCR_HI)) begin
            region_s = REG_SCREEN;
        end else if (addr_ext_s == KBD_A) begin
            region_s = REG_KBD;
        end else begin
            region_s = REG_ILLEGAL;
        end
    end

    assign ram_we_s = load && (region_s == REG_RAM);
    assign scr_we_s = load && (region_s == REG_SCREEN);
    assign kbd_rd_s = !load && (region_s == REG_KBD);

    dp_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RAM_DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_a    (ram_we_s),
        .addr_a  (ram_addr_s),
        .wdata_a (in),
        .rdata_a (ram_q_s),
        .addr_b  ({RAM_AW{1'b0}}),
        .rdata_b (ram_b_unused_s)
    );

    dp_ram #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SCREEN_DEPTH),
        .AW    (SCREEN_AW)
    ) u_screen (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_a    (scr_we_s),
        .addr_a  (scr_addr_s),
        .wdata_a (in),
        .rdata_a (scr_q_s),
        .addr_b  (scr_rd_addr),
        .rdata_b (scr_rd_data)
    );

    // Keyboard register: a strobe wins over a read-clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kbd_r         <= {DATA_WIDTH{1'b0}};
            kbd_pending_r <= 1'b0;
        end else if (kbd_strobe) begin
            kbd_r         <= kbd_code;
            kbd_pending_r <= KBD_LATCH;
        end else if (KBD_LATCH && kbd_rd_s) begin
            kbd_r         <= {DATA_WIDTH{1'b0}};
            kbd_pending_r <= 1'b0;
        end else begin
            kbd_r         <= kbd_r;
            kbd_pending_r <= kbd_pending_r;
        end
    end

    // Read-side pipeline: remembered region, keyboard snapshot, error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_q_r   <= REG_ILLEGAL;
            kbd_q_r      <= {DATA_WIDTH{1'b0}};
            addr_error_r <= 1'b0;
        end else begin
            region_q_r   <= region_s;
            kbd_q_r      <= kbd_rd_s ? kbd_r : {DATA_WIDTH{1'b0}};
            addr_error_r <= (region_s == REG_ILLEGAL) || (load && (region_s == REG_KBD));
        end
    end

    // Select among already-registered sources; illegal and KBD writes read as 0.
    always_comb begin
        out_s = {DATA_WIDTH{1'b0}};
        case (region_q_r)
            REG_RAM:    out_s = ram_q_s;
            REG_SCREEN: out_s = scr_q_s;
            REG_KBD:    out_s = kbd_q_r;
            default:    out_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    assign out         = out_s;
    assign addr_error  = addr_error_r;
    assign kbd_pending = kbd_pending_r;

endmodule

// File: tb/tb_mapped_memory.sv
// Directed self-checking bench for mapped_memory with default parameters.
module tb_mapped_memory;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic [14:0] address;
    logic        load;
    logic [15:0] out;
    logic        addr_error;
    logic [15:0] kbd_code;
    logic        kbd_strobe;
    logic        kbd_pending;
    logic [12:0] scr_rd_addr;
    logic [15:0] scr_rd_data;

    int errors = 0;
    int checks = 0;

    mapped_memory dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .address     (address),
        .load        (load),
        .out         (out),
        .addr_error  (addr_error),
        .kbd_code    (kbd_code),
        .kbd_strobe  (kbd_strobe),
        .kbd_pending (kbd_pending),
        .scr_rd_addr (scr_rd_addr),
        .scr_rd_data (scr_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        in          = 16'h0000;
        address     = 15'd0;
        load        = 1'b0;
        kbd_code    = 16'h0000;
        kbd_strobe  = 1'b0;
        scr_rd_addr = 13'd0;
        #2;
        check_val("rst_out", out, 16'h0000);
        check_val("rst_err", {15'd0, addr_error}, 16'h0000);
        check_val("rst_pend", {15'd0, kbd_pending}, 16'h0000);
        check_val("rst_scr", scr_rd_data, 16'h0000);
        #10;
        rst_n = 1'b1;
        tick();

        // RAM write then read at the top RAM word
        load = 1'b1; address = 15'd16383; in = 16'hA5C3;
        tick();
        check_val("ram_wr_err", {15'd0, addr_error}, 16'h0000);
        load = 1'b0;
        tick();
        check_val("ram_rd", out, 16'hA5C3);
        check_val("ram_rd_err", {15'd0, addr_error}, 16'h0000);

        // Screen via CPU write, display read, then read-first on both ports
        load = 1'b1; address = 15'd16384; in = 16'h0070;
        tick();
        load = 1'b0; scr_rd_addr = 13'd0;
        tick();
        check_val("scr_disp", scr_rd_data, 16'h0070);
        check_val("scr_cpu", out, 16'h0070);
        load = 1'b1; in = 16'h00FF;
        tick();
        check_val("scr_disp_old", scr_rd_data, 16'h0070);
        check_val("scr_cpu_old", out, 16'h0070);
        load = 1'b0;
        tick();
        check_val("scr_disp_new", scr_rd_data, 16'h00FF);
        check_val("scr_cpu_new", out, 16'h00FF);

        // Keyboard latch and clear-on-read
        address = 15'd0; kbd_code = 16'h0041; kbd_strobe = 1'b1;
        tick();
        kbd_strobe = 1'b0;
        check_val("kbd_pend_set", {15'd0, kbd_pending}, 16'h0001);
        address = 15'd24576;
        tick();
        check_val("kbd_rd1", out, 16'h0041);
        check_val("kbd_pend_clr", {15'd0, kbd_pending}, 16'h0000);
        tick();
        check_val("kbd_rd2", out, 16'h0000);

        // Strobe coinciding with the read-clear edge
        address = 15'd0; kbd_code = 16'h0041; kbd_strobe = 1'b1;
        tick();
        address = 15'd24576; kbd_code = 16'h0042;
        tick();
        kbd_strobe = 1'b0;
        check_val("kbd_race_out", out, 16'h0041);
        check_val("kbd_race_pend", {15'd0, kbd_pending}, 16'h0001);
        tick();
        check_val("kbd_race_new", out, 16'h0042);
        check_val("kbd_race_clr", {15'd0, kbd_pending}, 16'h0000);

        // Illegal write, KBD write, then error drops
        load = 1'b1; address = 15'd24577; in = 16'hFFFF;
        tick();
        check_val("ill_wr_err", {15'd0, addr_error}, 16'h0001);
        check_val("ill_wr_out", out, 16'h0000);
        address = 15'd0; kbd_code = 16'h0055; kbd_strobe = 1'b1; load = 1'b0;
        tick();
        check_val("ill_gap_err", {15'd0, addr_error}, 16'h0000);
        kbd_strobe = 1'b0; load = 1'b1; address = 15'd24576; in = 16'hFFFF;
        tick();
        check_val("kbd_wr_err", {15'd0, addr_error}, 16'h0001);
        check_val("kbd_wr_pend", {15'd0, kbd_pending}, 16'h0001);
        load = 1'b0;
        tick();
        check_val("kbd_wr_gone", {15'd0, addr_error}, 16'h0000);
        check_val("kbd_unchanged", out, 16'h0055);

        // Illegal read with load low
        address = 15'd30000;
        tick();
        check_val("ill_rd_err", {15'd0, addr_error}, 16'h0001);
        check_val("ill_rd_out", out, 16'h0000);
        address = 15'd0;
        tick();
        check_val("ill_rd_drop", {15'd0, addr_error}, 16'h0000);

        // Asynchronous reset mid-stream
        address = 15'd16383; kbd_code = 16'h0077; kbd_strobe = 1'b1;
        tick();
        kbd_strobe = 1'b0;
        check_val("pre_rst_out", out, 16'hA5C3);
        check_val("pre_rst_pend", {15'd0, kbd_pending}, 16'h0001);
        check_val("pre_rst_scr", scr_rd_data, 16'h00FF);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_out", out, 16'h0000);
        check_val("async_pend", {15'd0, kbd_pending}, 16'h0000);
        check_val("async_scr", scr_rd_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_ram", out, 16'hA5C3);
        address = 15'd24576;
        tick();
        check_val("post_rst_kbd", out, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
